// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state and owner encodings for the memory-port arbiter
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } arb_owner_e;

  function automatic arb_owner_e state_owner(input arb_state_e s);
    return (s == BUSY_DM) ? OWNER_DM : OWNER_IF;
  endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// rtl/arb_timeout_cnt.sv - counts busy cycles, flags expiry on the TIMEOUT-th cycle
module arb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the last allowed cycle so the abort lands exactly TIMEOUT cycles after grant.
  assign expired = enable && !clear && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter, data side over fetch; ARB_TIMEOUT_EN adds busy timeout
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_rd,
  input  logic                dm_wr,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_done,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                bus_err,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_e          state_q,     state_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                if_done_q,   if_done_d;
  logic                dm_done_q,   dm_done_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
  logic                bus_err_q,   bus_err_d;
  logic [DATA_W-1:0]   done_rdata;
  logic                timeout_expired;

`ifdef ARB_TIMEOUT_EN
  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == IDLE),
    .enable  (state_q != IDLE),
    .expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    bus_err_d   = 1'b0;
    done_rdata  = (mem_ready && !mem_we_q) ? mem_rdata : '0;

    case (state_q)
      IDLE: begin
        // The done cycle is the bubble: the requester only drops its request after seeing done.
        if (!if_done_q && !dm_done_q) begin
          if (dm_rd || dm_wr) begin
            state_d     = BUSY_DM;
            mem_req_d   = 1'b1;
            mem_we_d    = dm_wr;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wr ? dm_wdata : '0;
            mem_wstrb_d = dm_wr ? dm_wstrb : '0;
          end else if (if_req) begin
            state_d     = BUSY_IF;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready || timeout_expired) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = !mem_ready;
          if (state_owner(state_q) == OWNER_DM) begin
            dm_done_d  = 1'b1;
            dm_rdata_d = done_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = done_rdata;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = (dm_rd | dm_wr) & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter (ARB_TIMEOUT_EN selects the timeout scenario)
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        dm_rd;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic        bus_err;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_wstrb  (dm_wstrb),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .bus_err   (bus_err),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_wstrb = '0; mem_ready = 1'b0; mem_rdata = '0;
    nc(); nc();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_dm_done", dm_done, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall_if", stall_if, 0);
    rst_n = 1'b1;

    // stray mem_ready while idle
    mem_ready = 1'b1; mem_rdata = 32'h55;
    nc();
    chk("idle_ready_if_done", if_done, 0);
    chk("idle_ready_dm_done", dm_done, 0);
    chk("idle_ready_mem_req", mem_req, 0);
    mem_ready = 1'b0; mem_rdata = '0;

    // single fetch, ready two cycles after request
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk("f_stall_if_0", stall_if, 1);
    nc();
    chk("f_mem_req_1", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h100);
    chk("f_mem_we", mem_we, 0);
    chk("f_stall_if_1", stall_if, 1);
    chk("f_if_done_early", if_done, 0);
    nc();
    chk("f_mem_req_2", mem_req, 1);
    chk("f_stall_if_2", stall_if, 1);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    nc();
    chk("f_if_done", if_done, 1);
    chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_mem_req_off", mem_req, 0);
    chk("f_stall_if_off", stall_if, 0);
    chk("f_bus_err", bus_err, 0);
    if_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    nc();
    chk("f_if_done_pulse", if_done, 0);

    // simultaneous fetch and load: load first, bubble, then fetch
    if_req = 1'b1; if_addr = 32'h300; dm_rd = 1'b1; dm_addr = 32'h2000;
    nc();
    chk("p_mem_addr_dm", mem_addr, 32'h2000);
    chk("p_mem_req", mem_req, 1);
    chk("p_mem_we", mem_we, 0);
    chk("p_stall_mem", stall_mem, 1);
    chk("p_stall_if", stall_if, 1);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
    nc();
    chk("p_dm_done", dm_done, 1);
    chk("p_dm_rdata", dm_rdata, 32'hCAFE0001);
    chk("p_mem_req_off", mem_req, 0);
    chk("p_stall_mem_off", stall_mem, 0);
    chk("p_if_done_not", if_done, 0);
    dm_rd = 1'b0; mem_ready = 1'b0;
    nc();
    chk("p_bubble_req", mem_req, 0);
    chk("p_dm_done_pulse", dm_done, 0);
    nc();
    chk("p_if_mem_req", mem_req, 1);
    chk("p_if_mem_addr", mem_addr, 32'h300);
    mem_ready = 1'b1; mem_rdata = 32'h11112222;
    nc();
    chk("p_if_done", if_done, 1);
    chk("p_if_rdata", if_rdata, 32'h11112222);
    if_req = 1'b0; mem_ready = 1'b0;
    nc();

    // rd+wr together is a write; request dropped mid-transaction is not aborted
    dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678; dm_wstrb = 4'h3;
    nc();
    chk("w_mem_we", mem_we, 1);
    chk("w_mem_wdata", mem_wdata, 32'h12345678);
    chk("w_mem_wstrb", mem_wstrb, 4'h3);
    chk("w_mem_addr", mem_addr, 32'h40);
    dm_rd = 1'b0; dm_wr = 1'b0; dm_wdata = '0; dm_wstrb = '0;
    nc();
    chk("w_hold_req", mem_req, 1);
    chk("w_hold_we", mem_we, 1);
    chk("w_hold_wdata", mem_wdata, 32'h12345678);
    chk("w_hold_wstrb", mem_wstrb, 4'h3);
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    nc();
    chk("w_dm_done", dm_done, 1);
    chk("w_dm_rdata_zero", dm_rdata, 0);
    chk("w_mem_req_off", mem_req, 0);
    mem_ready = 1'b0; mem_rdata = '0;
    nc();
    chk("w_dm_done_pulse", dm_done, 0);

    // continuous data requests starve the fetch
    dm_rd = 1'b1; dm_addr = 32'h500; if_req = 1'b1; if_addr = 32'h600;
    nc();
    chk("s_addr_500", mem_addr, 32'h500);
    mem_ready = 1'b1; mem_rdata = 32'h1;
    nc();
    chk("s_dm_done_1", dm_done, 1);
    dm_addr = 32'h504; mem_ready = 1'b0;
    nc();
    chk("s_bubble_1", mem_req, 0);
    nc();
    chk("s_addr_504", mem_addr, 32'h504);
    chk("s_stall_if", stall_if, 1);
    mem_ready = 1'b1; mem_rdata = 32'h2;
    nc();
    chk("s_dm_done_2", dm_done, 1);
    chk("s_dm_rdata_2", dm_rdata, 32'h2);
    dm_rd = 1'b0; mem_ready = 1'b0;
    nc();
    chk("s_bubble_2", mem_req, 0);
    nc();
    chk("s_if_req", mem_req, 1);
    chk("s_addr_600", mem_addr, 32'h600);
    mem_ready = 1'b1; mem_rdata = 32'h3;
    nc();
    chk("s_if_done", if_done, 1);
    chk("s_if_rdata", if_rdata, 32'h3);
    if_req = 1'b0; mem_ready = 1'b0;
    nc();

    dm_rd = 1'b1; dm_addr = 32'h700;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      nc();
      chk($sformatf("t_req_cycle%0d", k), mem_req, 1);
      chk($sformatf("t_no_done_cycle%0d", k), dm_done, 0);
    end
    nc();
    chk("t_mem_req_drop", mem_req, 0);
    chk("t_dm_done", dm_done, 1);
    chk("t_bus_err", bus_err, 1);
    chk("t_dm_rdata", dm_rdata, 0);
    dm_rd = 1'b0;
    nc();
    chk("t_dm_done_pulse", dm_done, 0);
    chk("t_bus_err_pulse", bus_err, 0);
    dm_rd = 1'b1; dm_addr = 32'h704;
    nc();
    chk("t_regrant", mem_req, 1);
`else
    for (int k = 1; k <= 20; k++) begin
      nc();
      chk($sformatf("n_req_cycle%0d", k), mem_req, 1);
      chk($sformatf("n_no_done_cycle%0d", k), dm_done | bus_err, 0);
    end
`endif

    // asynchronous reset in the middle of a data transaction
    rst_n = 1'b0;
    #1;
    chk("r_mem_req", mem_req, 0);
    chk("r_mem_addr", mem_addr, 0);
    chk("r_mem_we", mem_we, 0);
    chk("r_dm_done", dm_done, 0);
    nc();
    rst_n = 1'b1; dm_rd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nc();
      chk($sformatf("r_no_done_%0d", k), dm_done, 0);
      chk($sformatf("r_idle_req_%0d", k), mem_req, 0);
    end
    if_req = 1'b1; if_addr = 32'h800;
    nc();
    chk("r_if_req", mem_req, 1);
    chk("r_if_addr", mem_addr, 32'h800);
    mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
    nc();
    chk("r_if_done", if_done, 1);
    chk("r_if_rdata", if_rdata, 32'hA5A5A5A5);
    chk("r_bus_err", bus_err, 0);
    if_req = 1'b0; mem_ready = 1'b0;
    nc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 16, max cycles awaiting mem_ready.
REQ-002 Ports SHALL be (name direction width meaning), clock and reset first:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  instruction-fetch read request
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle fetch completion pulse
- if_rdata  out  DATA_W  fetch data, valid with if_done
- dm_rd  in  1  load request (from control mem_read)
- dm_wr  in  1  store request (from control mem_write)
- dm_addr  in  ADDR_W  load/store address
- dm_wdata  in  DATA_W  store data
- dm_wstrb  in  DATA_W/8  store byte enables
- dm_done  out  1  one-cycle load/store completion pulse
- dm_rdata  out  DATA_W  load data, valid with dm_done
- bus_err  out  1  completion ended by timeout, valid with if_done/dm_done
- stall_if  out  1  fetch stage must hold
- stall_mem  out  1  memory stage must hold
- mem_req  out  1  memory-port request
- mem_we  out  1  memory-port write enable
- mem_addr  out  ADDR_W  memory-port address
- mem_wdata  out  DATA_W  memory-port write data
- mem_wstrb  out  DATA_W/8  memory-port byte enables
- mem_ready  in  1  memory-port accept/complete
- mem_rdata  in  DATA_W  memory-port read data, valid with mem_ready
REQ-003 Clock SHALL be clk; reset SHALL be rst_n, asynchronous, active-low.

Function
REQ-004 FSM SHALL have states IDLE, BUSY_IF, BUSY_DM; one outstanding transaction maximum.
REQ-005 In IDLE, dm request (dm_rd|dm_wr) SHALL win over if_req (fixed priority, older instruction first).
REQ-006 Grant SHALL capture address/data/strobe/we into registers at the edge and enter BUSY_x; mem_req SHALL assert the following cycle (1-cycle request latency).
REQ-007 dm_rd and dm_wr both high SHALL be treated as a write.
REQ-008 mem_req and all mem_* outputs SHALL stay stable until the cycle mem_ready is sampled high.
REQ-009 On mem_ready in BUSY_x: mem_req SHALL deassert next cycle, owner's done SHALL pulse exactly one cycle with registered rdata (write: rdata 0), state SHALL return to IDLE; next grant earliest the cycle after (1 bubble).
REQ-010 mem_ready while IDLE SHALL be ignored.
REQ-011 Requester deasserting its request mid-transaction SHALL NOT abort it; done still pulses.
REQ-012 stall_if SHALL equal if_req & ~if_done; stall_mem SHALL equal (dm_rd|dm_wr) & ~dm_done (combinational).
REQ-013 A fetch requested while dm continuously requests SHALL wait; no fairness override.

Reset
REQ-014 rst_n low SHALL immediately force IDLE, mem_req=0, mem_we=0, if_done=0, dm_done=0, bus_err=0, all data/address outputs 0, timeout counter 0.
REQ-015 Reset mid-transaction SHALL drop it without any done pulse.

Configuration
REQ-016 Macro ARB_TIMEOUT_EN defined: counter SHALL count BUSY cycles; on reaching TIMEOUT without mem_ready, mem_req SHALL drop, owner done SHALL pulse with bus_err=1, rdata=0, state IDLE.
REQ-017 Macro undefined: no counter, bus_err tied 0, BUSY waits indefinitely.

Structure
REQ-018 Shared package arb_pkg SHALL hold the state enum (IDLE/BUSY_IF/BUSY_DM) and owner encoding.
REQ-019 Timeout logic SHALL be sub-module arb_timeout_cnt (clear, enable, expired), instantiated only under ARB_TIMEOUT_EN.

Verification
REQ-020 if_req, addr 0x100, mem_ready 2 cycles after mem_req, rdata 0xDEADBEEF -> if_done one cycle, if_rdata 0xDEADBEEF, stall_if high until then.
REQ-021 if_req and dm_rd same cycle, dm_addr 0x2000 -> first mem_addr 0x2000; fetch issued after dm_done plus one bubble.
REQ-022 dm_wr, wdata 0x12345678, wstrb 0x3 -> mem_we=1, mem_wdata/mem_wstrb match and stable until mem_ready.
REQ-023 ARB_TIMEOUT_EN, TIMEOUT=16, mem_ready never -> mem_req drops after 16 cycles, dm_done with bus_err=1.
REQ-024 rst_n low while BUSY_DM -> mem_req 0 immediately, no dm_done; post-reset if_req served normally.
